// File: rtl/is_array_feeder_if.sv
// Memory-side valid/ready streams plus the systolic array input buses.
// The feeder owns the master view and the environment owns the slave view.
interface is_array_feeder_if #(
    parameter int D_W = 8,
    parameter int N   = 8
) ();
    logic               w_valid;
    logic               w_ready;
    logic [N*D_W-1:0]   w_data;
    logic               a_valid;
    logic               a_ready;
    logic [N*D_W-1:0]   a_data;
    logic               load_weight;
    logic [N*D_W-1:0]   m1;
    logic [N*D_W-1:0]   m0;

    modport master (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, load_weight, m1, m0
    );

    modport slave (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, load_weight, m1, m0
    );
endinterface

// File: rtl/is_array_feeder.sv
// Sequencer feeding an input-stationary systolic array: loads N weight rows on m1,
// then streams skewed activation vectors on m0, drains the skew tail and pulses done.
module is_array_feeder #(
    parameter int D_W   = 8,
    parameter int N     = 8,
    parameter int T_MAX = 1024,
    parameter int SKEW  = 1,
    parameter int CW    = $clog2(T_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CW-1:0]     num_vecs,
    is_array_feeder_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [1:0]        phase,
    output logic [15:0]       stall_cnt
);
    localparam int DRAIN_CYC = (N - 1) * SKEW;
    localparam int RCW       = $clog2(N + 1);
    localparam int DCW       = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_GAP    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_s;
    state_t           tail_s;
    logic [CW-1:0]    num_r;
    logic [CW-1:0]    vec_cnt_r;
    logic [RCW-1:0]   row_cnt_r;
    logic [DCW-1:0]   drain_cnt_r;
    logic             w_ready_r;
    logic             a_ready_r;
    logic             load_weight_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       phase_r;
    logic [15:0]      stall_r;
    logic [N*D_W-1:0] m1_r;
    logic [N*D_W-1:0] m0_r;
    logic [N*D_W-1:0] vec_r;
    logic [N*D_W-1:0] m0_s;
    logic             w_acc_s;
    logic             a_acc_s;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_IDLE:            phase_of = 2'd0;
            S_LOAD_W:          phase_of = 2'd1;
            S_STREAM, S_DRAIN: phase_of = 2'd2;
            S_GAP, S_DONE:     phase_of = 2'd3;
            default:           phase_of = 2'd0;
        endcase
    endfunction

    assign w_acc_s = bus.w_valid && w_ready_r;
    assign a_acc_s = bus.a_valid && a_ready_r;
    // Without skew there is no tail to drain, so DRAIN is bypassed entirely.
    assign tail_s  = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   if (start) state_s = S_LOAD_W; else state_s = S_IDLE;
            S_LOAD_W: if (w_acc_s && row_cnt_r == '0) state_s = S_GAP; else state_s = S_LOAD_W;
            S_GAP:    if (num_r == '0) state_s = tail_s; else state_s = S_STREAM;
            S_STREAM: if (a_acc_s && vec_cnt_r == num_r - CW'(1)) state_s = tail_s;
                      else state_s = S_STREAM;
            S_DRAIN:  if (drain_cnt_r == DCW'(DRAIN_CYC - 1)) state_s = S_DONE;
                      else state_s = S_DRAIN;
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State, job counters and registered outputs; readies and status follow the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            num_r         <= '0;
            vec_cnt_r     <= '0;
            row_cnt_r     <= '0;
            drain_cnt_r   <= '0;
            w_ready_r     <= 1'b0;
            a_ready_r     <= 1'b0;
            load_weight_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            phase_r       <= 2'd0;
            stall_r       <= 16'd0;
            m1_r          <= '0;
            m0_r          <= '0;
            vec_r         <= '0;
        end else begin
            state_r       <= state_s;
            w_ready_r     <= (state_s == S_LOAD_W);
            a_ready_r     <= (state_s == S_STREAM);
            busy_r        <= (state_s != S_IDLE);
            done_r        <= (state_s == S_DONE);
            phase_r       <= phase_of(state_s);
            // The GAP-state write is the zero bubble that ends weight loading.
            load_weight_r <= w_acc_s;
            m1_r          <= w_acc_s ? bus.w_data : '0;
            vec_r         <= a_acc_s ? bus.a_data : '0;
            m0_r          <= m0_s;
            if (state_r == S_IDLE && start) begin
                num_r       <= (num_vecs > CW'(T_MAX)) ? CW'(T_MAX) : num_vecs;
                row_cnt_r   <= RCW'(N - 1);
                vec_cnt_r   <= '0;
                drain_cnt_r <= '0;
                stall_r     <= 16'd0;
            end else begin
                if (w_acc_s) row_cnt_r <= row_cnt_r - RCW'(1);
                if (a_acc_s) vec_cnt_r <= vec_cnt_r + CW'(1);
                if (state_r == S_STREAM && !bus.a_valid && stall_r != 16'hFFFF)
                    stall_r <= stall_r + 16'd1;
                if (state_r == S_DRAIN) drain_cnt_r <= drain_cnt_r + DCW'(1);
            end
        end
    end

    // Lane r of every entered vector is delayed r*SKEW extra cycles for the diagonal feed.
    for (genvar r = 0; r < N; r++) begin : g_lane
        localparam int DEP = r * SKEW;
        if (DEP == 0) begin : g_direct
            assign m0_s[r*D_W +: D_W] = vec_r[r*D_W +: D_W];
        end else begin : g_delay
            logic [D_W-1:0] dly_r [DEP];
            // Per-lane skew shift register, cleared by reset so no tail survives an abort.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEP; i++) dly_r[i] <= '0;
                end else begin
                    dly_r[0] <= vec_r[r*D_W +: D_W];
                    for (int i = 1; i < DEP; i++) dly_r[i] <= dly_r[i-1];
                end
            end
            assign m0_s[r*D_W +: D_W] = dly_r[DEP-1];
        end
    end

    assign bus.w_ready     = w_ready_r;
    assign bus.a_ready     = a_ready_r;
    assign bus.load_weight = load_weight_r;
    assign bus.m1          = m1_r;
    assign bus.m0          = m0_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign phase           = phase_r;
    assign stall_cnt       = stall_r;
endmodule

// File: tb/tb_is_array_feeder.sv
// Randomized bench for is_array_feeder: each job's expected per-cycle outputs are
// derived from acceptance timelines computed up front from the valid patterns.
module tb_is_array_feeder;
    localparam int D_W   = 8;
    localparam int N     = 8;
    localparam int T_MAX = 1024;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int NB    = N * D_W;
    localparam int MAXC  = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vecs = '0;
    logic          busy;
    logic          done;
    logic [1:0]    phase;
    logic [15:0]   stall_cnt;

    is_array_feeder_if #(.D_W(D_W), .N(N)) bus ();

    is_array_feeder #(.D_W(D_W), .N(N), .T_MAX(T_MAX), .SKEW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_vecs  (num_vecs),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .phase     (phase),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cur_job = 0;
    int cur_c   = 0;

    bit            wv   [MAXC];
    bit            av   [MAXC];
    bit            wacc [MAXC];
    bit            aacc [MAXC];
    logic [NB-1:0] wd   [MAXC];
    logic [NB-1:0] ad   [MAXC];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s job%0d cyc%0d: got %0h expected %0h", tag, cur_job, cur_c, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_lw"},    64'(bus.load_weight), 64'd0);
        check_eq({tag, "_m1"},    64'(bus.m1),          64'd0);
        check_eq({tag, "_m0"},    64'(bus.m0),          64'd0);
        check_eq({tag, "_wrdy"},  64'(bus.w_ready),     64'd0);
        check_eq({tag, "_ardy"},  64'(bus.a_ready),     64'd0);
        check_eq({tag, "_busy"},  64'(busy),            64'd0);
        check_eq({tag, "_done"},  64'(done),            64'd0);
        check_eq({tag, "_phase"}, 64'(phase),           64'd0);
        check_eq({tag, "_stall"}, 64'(stall_cnt),       64'd0);
    endtask

    // wmode: 0 random, 1 always valid, 2 holes at cycles 3 and 5.
    // amode: 0 random 60%, 1 always valid, 2 alternating from stream start, 3 random 80%.
    // dmode: 0 random data, 1 rows = cycle+1 per lane and vectors all 0x11.
    // rst_at: stream cycle index at which reset is pulsed, or -1.
    task automatic run_job(input int n_req, input int wmode, input int amode,
                           input int dmode, input int rst_at);
        int n, L, s_end, done_c, last_c, rst_c, cnt, c, src;
        int exp_stall, lw_obs, ndone, done_obs, acc_obs, stall_done;
        logic          e_lw;
        logic [1:0]    e_phase;
        logic [NB-1:0] e_m0;
        logic [NB-1:0] e_m1;
        bit            in_stream;

        cur_job++;
        n = (n_req > T_MAX) ? T_MAX : n_req;
        for (int i = 0; i < MAXC; i++) begin
            wacc[i] = 1'b0;
            aacc[i] = 1'b0;
            case (wmode)
                1:       wv[i] = 1'b1;
                2:       wv[i] = !(i == 3 || i == 5);
                default: wv[i] = ($urandom_range(99, 0) < 70);
            endcase
            wd[i] = (dmode == 1) ? {N{8'(i + 1)}} : {$urandom, $urandom};
            ad[i] = (dmode == 1) ? {N{8'h11}}     : {$urandom, $urandom};
        end
        cnt = 0;
        c   = 0;
        while (cnt < N) begin
            if (wv[c]) begin
                wacc[c] = 1'b1;
                cnt++;
            end
            c++;
        end
        L = c - 1;
        for (int i = 0; i < MAXC; i++) begin
            if (i < L + 2)      av[i] = ($urandom_range(1, 0) == 1);
            else if (amode == 1) av[i] = 1'b1;
            else if (amode == 2) av[i] = ((i - L - 2) % 2 == 0);
            else if (amode == 3) av[i] = ($urandom_range(99, 0) < 80);
            else                 av[i] = ($urandom_range(99, 0) < 60);
        end
        cnt   = 0;
        c     = L + 2;
        s_end = L + 1;
        while (cnt < n && c < MAXC - 16) begin
            if (av[c]) begin
                aacc[c] = 1'b1;
                cnt++;
            end
            s_end = c;
            c++;
        end
        done_c = ((n > 0) ? s_end + 1 : L + 2) + (N - 1);
        last_c = done_c + 2;
        rst_c  = (rst_at >= 0) ? L + 2 + rst_at : -1;

        @(posedge clk); #1;
        cur_c = -1;
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_wrdy", 64'(bus.w_ready), 64'd0);
        start       = 1'b1;
        num_vecs    = CW'(n_req);
        bus.w_valid = ($urandom_range(1, 0) == 1);
        bus.w_data  = {$urandom, $urandom};
        bus.a_valid = ($urandom_range(1, 0) == 1);
        bus.a_data  = {$urandom, $urandom};
        exp_stall = 0; lw_obs = 0; ndone = 0; done_obs = -1; acc_obs = 0; stall_done = -1;

        for (c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            cur_c = c;
            e_lw = 1'b0;
            e_m1 = '0;
            if (c >= 1) begin
                if (wacc[c-1]) begin
                    e_lw = 1'b1;
                    e_m1 = wd[c-1];
                end
            end
            e_m0 = '0;
            for (int r = 0; r < N; r++) begin
                src = c - 2 - r;
                if (src >= 0) begin
                    if (aacc[src]) e_m0[r*D_W +: D_W] = ad[src][r*D_W +: D_W];
                end
            end
            if (c <= L)                          e_phase = 2'd1;
            else if (c == L + 1 || c == done_c)  e_phase = 2'd3;
            else if (c < done_c)                 e_phase = 2'd2;
            else                                 e_phase = 2'd0;
            in_stream = (n > 0 && c >= L + 2 && c <= s_end);

            check_eq("load_weight", 64'(bus.load_weight), 64'(e_lw));
            check_eq("m1",          64'(bus.m1),          64'(e_m1));
            check_eq("m0",          64'(bus.m0),          64'(e_m0));
            check_eq("w_ready",     64'(bus.w_ready),     64'(c <= L));
            check_eq("a_ready",     64'(bus.a_ready),     64'(in_stream));
            check_eq("ready_excl",  64'(bus.w_ready && bus.a_ready), 64'd0);
            check_eq("busy",        64'(busy),            64'(c <= done_c));
            check_eq("done",        64'(done),            64'(c == done_c));
            check_eq("phase",       64'(phase),           64'(e_phase));
            check_eq("stall_cnt",   64'(stall_cnt),       64'(exp_stall));

            if (bus.load_weight) lw_obs++;
            if (done) begin
                ndone++;
                done_obs   = c;
                stall_done = int'(stall_cnt);
            end
            if (in_stream && !av[c]) exp_stall++;

            if (c == rst_c) begin
                rst   = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                cur_c = c + 1;
                check_zero("rst_edge");
                rst = 1'b1;
                @(posedge clk); #1;
                cur_c = c + 2;
                check_zero("rst_after");
                return;
            end

            start       = (c <= done_c) ? ($urandom_range(1, 0) == 1) : 1'b0;
            num_vecs    = CW'($urandom_range(T_MAX, 0));
            bus.w_valid = wv[c];
            bus.w_data  = wd[c];
            bus.a_valid = av[c];
            bus.a_data  = ad[c];
            if (bus.a_valid && bus.a_ready) acc_obs++;
        end

        check_eq("lw_count",   64'(lw_obs),  64'(N));
        check_eq("done_count", 64'(ndone),   64'd1);
        check_eq("acc_count",  64'(acc_obs), 64'(n));
        if (cur_job == 1) check_eq("t1_len",   64'(done_obs + 2), 64'd22);
        if (cur_job == 3) check_eq("t3_stall", 64'(stall_done),   64'd5);
        if (cur_job == 5) check_eq("t5_clamp", 64'(acc_obs),      64'd1024);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cur_c = 0;
        check_zero("reset");
        rst = 1'b1;

        run_job(4,    1, 1, 1, -1);
        run_job(5,    2, 0, 0, -1);
        run_job(6,    1, 2, 0, -1);
        run_job(0,    0, 0, 0, -1);
        run_job(2000, 1, 3, 0, -1);
        run_job(6,    1, 1, 0,  2);
        run_job(3,    0, 0, 0, -1);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(20, 0)), 0, 0, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
